expansor_vizinhos_multicanal: RTL and testbench

EXPANSOR_VIZINHOS_MULTICANAL -- requirements
Module: expansor_vizinhos_multicanal

---
 rtl/expansor_vizinhos_multicanal.sv | 215 +++++++++++++++++++++
 tb/tb_expansor_vizinhos_multicanal.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expansor_vizinhos_multicanal.sv
// expansor_vizinhos_multicanal: expands the neighbours of up to NUM_NA approved
// nodes. It first marks every approved node as established (and deactivates it
// in the active evaluator), then walks each node's relation slots. Any neighbour
// that is valid, not the node itself, not an obstacle and not yet established
// produces a valid/ready update request.
// Optional build macro: EVM_DIST_SATURACAO_EN saturates candidate distances
// instead of letting them wrap.
module expansor_vizinhos_multicanal #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DISTANCIA_WIDTH = 6,
  parameter int CUSTO_WIDTH     = 4,
  parameter int MAX_VIZINHOS    = 8,
  parameter int NUM_NA          = 4,
  parameter int MEM_LATENCIA    = 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        expandir_in,
  input  logic [NUM_NA-1:0]                           aprovado_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]                endereco_in,
  input  logic [DISTANCIA_WIDTH*NUM_NA-1:0]           distancia_in,
  input  logic                                        aa_ocupado_in,
  output logic                                        relacoes_rd_en_out,
  output logic [ADDR_WIDTH-1:0]                       relacoes_rd_addr_out,
  input  logic [MAX_VIZINHOS*(ADDR_WIDTH+CUSTO_WIDTH)-1:0] relacoes_rd_data_in,
  output logic                                        obstaculos_rd_en_out,
  output logic [ADDR_WIDTH-1:0]                       obstaculos_rd_addr_out,
  input  logic                                        obstaculos_rd_data_in,
  output logic                                        estabelecidos_rd_en_out,
  output logic [ADDR_WIDTH-1:0]                       estabelecidos_rd_addr_out,
  input  logic                                        estabelecidos_rd_data_in,
  output logic                                        estabelecidos_wr_en_out,
  output logic [ADDR_WIDTH-1:0]                       estabelecidos_wr_addr_out,
  output logic                                        desativar_out,
  output logic [ADDR_WIDTH-1:0]                       desativar_addr_out,
  output logic                                        atualizar_valid_out,
  input  logic                                        atualizar_ready_in,
  output logic [ADDR_WIDTH-1:0]                       atualizar_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0]                  atualizar_distancia_out,
  output logic [ADDR_WIDTH-1:0]                       atualizar_anterior_out,
  output logic                                        pronto_out
);
  localparam int SW   = ADDR_WIDTH + CUSTO_WIDTH;
  localparam int DW1  = DISTANCIA_WIDTH + 1;
  localparam int CH_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
  localparam int SL_W = $clog2(MAX_VIZINHOS);
  localparam logic [ADDR_WIDTH-1:0] INVALIDO   = '1;
  localparam logic [1:0]            ULT_ESPERA = 2'(MEM_LATENCIA - 1);
  localparam logic [SL_W-1:0]       ULT_SLOT   = SL_W'(MAX_VIZINHOS - 1);

  typedef enum logic [3:0] {
    IDLE, ESTABELECER, LER_REL, ESPERA_REL, CONSULTA, ESPERA_CONS, EMITIR, PROXIMO, FINAL
  } estado_t;

  estado_t                                r_estado;
  logic [NUM_NA-1:0]                      r_mask, r_pend;
  logic [NUM_NA-1:0][ADDR_WIDTH-1:0]      r_addr;
  logic [NUM_NA-1:0][DISTANCIA_WIDTH-1:0] r_dist;
  logic [CH_W-1:0]                        r_ch;
  logic [SL_W-1:0]                        r_slot;
  logic [1:0]                             r_espera;
  logic [MAX_VIZINHOS*SW-1:0]             r_rel;
  logic [ADDR_WIDTH-1:0]                  r_upd_addr, r_upd_ant;
  logic [DISTANCIA_WIDTH-1:0]             r_upd_dist;

  logic [CH_W-1:0]            w_est_ch, w_adv_ch;
  logic [NUM_NA-1:0]          w_pend_resto, w_pend_prox, w_adv_pend;
  logic [SW-1:0]              w_slot;
  logic [ADDR_WIDTH-1:0]      w_viz_addr, w_self;
  logic [CUSTO_WIDTH-1:0]     w_viz_custo;
  logic [DW1-1:0]             w_soma;
  logic [DISTANCIA_WIDTH-1:0] w_cand;
  logic                       w_pular, w_consulta, w_estab;
  logic [SL_W-1:0]            w_adv_slot;
  estado_t                    w_adv_estado;

  // Lowest-index set bit of a channel mask.
  function automatic logic [CH_W-1:0] f_menor(input logic [NUM_NA-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_NA - 1; i >= 0; i--) if (m[i]) idx = CH_W'(i);
    return idx;
  endfunction

  // Current slot decode, candidate distance and the slot/channel advance step.
  always_comb begin
    w_slot = '0;
    for (int k = 0; k < MAX_VIZINHOS; k++)
      if (r_slot == SL_W'(k)) w_slot = r_rel[(MAX_VIZINHOS-1-k)*SW +: SW];
    w_viz_addr  = w_slot[SW-1:CUSTO_WIDTH];
    w_viz_custo = w_slot[CUSTO_WIDTH-1:0];
    w_self      = r_addr[r_ch];
    w_pular     = (w_viz_addr == INVALIDO) || (w_viz_addr == w_self);
    w_soma      = {1'b0, r_dist[r_ch]} + DW1'(w_viz_custo);
`ifdef EVM_DIST_SATURACAO_EN
    w_cand      = w_soma[DISTANCIA_WIDTH] ? '1 : w_soma[DISTANCIA_WIDTH-1:0];
`else
    w_cand      = w_soma[DISTANCIA_WIDTH-1:0];
`endif
    w_est_ch    = f_menor(r_pend);
    w_pend_resto = r_pend;
    w_pend_resto[w_est_ch] = 1'b0;
    w_pend_prox = r_pend;
    w_pend_prox[r_ch] = 1'b0;
    // After the last slot the channel retires and the next pending one starts.
    w_adv_estado = CONSULTA;
    w_adv_slot   = r_slot + 1'b1;
    w_adv_ch     = r_ch;
    w_adv_pend   = r_pend;
    if (r_slot == ULT_SLOT) begin
      w_adv_slot   = '0;
      w_adv_pend   = w_pend_prox;
      w_adv_ch     = f_menor(w_pend_prox);
      w_adv_estado = (|w_pend_prox) ? LER_REL : FINAL;
    end
  end

  // Control FSM: establish all approved nodes, then expand them in index order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= IDLE;
      r_mask     <= '0;
      r_pend     <= '0;
      r_addr     <= '0;
      r_dist     <= '0;
      r_ch       <= '0;
      r_slot     <= '0;
      r_espera   <= '0;
      r_rel      <= '0;
      r_upd_addr <= '0;
      r_upd_ant  <= '0;
      r_upd_dist <= '0;
    end else begin
      case (r_estado)
        IDLE: if (expandir_in) begin
          r_mask   <= aprovado_in;
          r_pend   <= aprovado_in;
          r_addr   <= endereco_in;
          r_dist   <= distancia_in;
          r_estado <= (|aprovado_in) ? ESTABELECER : FINAL;
        end
        ESTABELECER: if (!aa_ocupado_in) begin
          if (|w_pend_resto) r_pend <= w_pend_resto;
          else begin
            r_pend   <= r_mask;
            r_ch     <= f_menor(r_mask);
            r_estado <= LER_REL;
          end
        end
        LER_REL: begin
          r_espera <= '0;
          r_estado <= ESPERA_REL;
        end
        ESPERA_REL: begin
          if (r_espera == ULT_ESPERA) begin
            r_rel    <= relacoes_rd_data_in;
            r_slot   <= '0;
            r_estado <= CONSULTA;
          end else r_espera <= r_espera + 1'b1;
        end
        CONSULTA: begin
          if (w_pular) begin
            r_estado <= w_adv_estado;
            r_slot   <= w_adv_slot;
            r_ch     <= w_adv_ch;
            r_pend   <= w_adv_pend;
          end else begin
            r_espera <= '0;
            r_estado <= ESPERA_CONS;
          end
        end
        ESPERA_CONS: begin
          if (r_espera == ULT_ESPERA) begin
            if (!obstaculos_rd_data_in && !estabelecidos_rd_data_in) begin
              r_upd_addr <= w_viz_addr;
              r_upd_dist <= w_cand;
              r_upd_ant  <= w_self;
              r_estado   <= EMITIR;
            end else r_estado <= PROXIMO;
          end else r_espera <= r_espera + 1'b1;
        end
        EMITIR: if (atualizar_ready_in) r_estado <= PROXIMO;
        PROXIMO: begin
          r_estado <= w_adv_estado;
          r_slot   <= w_adv_slot;
          r_ch     <= w_adv_ch;
          r_pend   <= w_adv_pend;
        end
        FINAL:   r_estado <= IDLE;
        default: r_estado <= IDLE;
      endcase
    end
  end

  // Establish strobes follow the busy input in the same cycle so that no
  // deactivation is ever issued while the active evaluator is busy.
  assign w_estab    = (r_estado == ESTABELECER) && !aa_ocupado_in;
  assign w_consulta = (r_estado == CONSULTA) && !w_pular;

  assign estabelecidos_wr_en_out   = w_estab;
  assign estabelecidos_wr_addr_out = w_estab ? r_addr[w_est_ch] : '0;
  assign desativar_out             = w_estab;
  assign desativar_addr_out        = w_estab ? r_addr[w_est_ch] : '0;
  assign relacoes_rd_en_out        = (r_estado == LER_REL);
  assign relacoes_rd_addr_out      = relacoes_rd_en_out ? w_self : '0;
  assign obstaculos_rd_en_out      = w_consulta;
  assign obstaculos_rd_addr_out    = w_consulta ? w_viz_addr : '0;
  assign estabelecidos_rd_en_out   = w_consulta;
  assign estabelecidos_rd_addr_out = w_consulta ? w_viz_addr : '0;
  assign atualizar_valid_out       = (r_estado == EMITIR);
  assign atualizar_endereco_out    = r_upd_addr;
  assign atualizar_distancia_out   = r_upd_dist;
  assign atualizar_anterior_out    = r_upd_ant;
  assign pronto_out                = (r_estado == FINAL);
endmodule

// File: tb/tb_expansor_vizinhos_multicanal.sv
// Bench for expansor_vizinhos_multicanal: memory models with latency LAT,
// directed scenarios plus randomized runs against a list-based reference model.
module tb_expansor_vizinhos_multicanal;
  localparam int AW = 10, DW = 6, CW = 4, MV = 8, NA = 4, LAT = 3;
  localparam int SW = AW + CW;
  localparam logic [AW-1:0] INV = '1;
`ifdef EVM_DIST_SATURACAO_EN
  localparam int SAT_EXP = 63;
`else
  localparam int SAT_EXP = 2;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] p;
  } upd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic expandir_in = 1'b0, aa_ocupado_in = 1'b0, atualizar_ready_in = 1'b0;
  logic [NA-1:0] aprovado_in = '0;
  logic [AW*NA-1:0] endereco_in = '0;
  logic [DW*NA-1:0] distancia_in = '0;
  logic relacoes_rd_en_out, obstaculos_rd_en_out, estabelecidos_rd_en_out;
  logic estabelecidos_wr_en_out, desativar_out, atualizar_valid_out, pronto_out;
  logic [AW-1:0] relacoes_rd_addr_out, obstaculos_rd_addr_out, estabelecidos_rd_addr_out;
  logic [AW-1:0] estabelecidos_wr_addr_out, desativar_addr_out;
  logic [AW-1:0] atualizar_endereco_out, atualizar_anterior_out;
  logic [DW-1:0] atualizar_distancia_out;
  logic [MV*SW-1:0] relacoes_rd_data_in;
  logic obstaculos_rd_data_in, estabelecidos_rd_data_in;

  expansor_vizinhos_multicanal #(
    .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW),
    .MAX_VIZINHOS(MV), .NUM_NA(NA), .MEM_LATENCIA(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .expandir_in(expandir_in), .aprovado_in(aprovado_in),
    .endereco_in(endereco_in), .distancia_in(distancia_in), .aa_ocupado_in(aa_ocupado_in),
    .relacoes_rd_en_out(relacoes_rd_en_out), .relacoes_rd_addr_out(relacoes_rd_addr_out),
    .relacoes_rd_data_in(relacoes_rd_data_in),
    .obstaculos_rd_en_out(obstaculos_rd_en_out), .obstaculos_rd_addr_out(obstaculos_rd_addr_out),
    .obstaculos_rd_data_in(obstaculos_rd_data_in),
    .estabelecidos_rd_en_out(estabelecidos_rd_en_out),
    .estabelecidos_rd_addr_out(estabelecidos_rd_addr_out),
    .estabelecidos_rd_data_in(estabelecidos_rd_data_in),
    .estabelecidos_wr_en_out(estabelecidos_wr_en_out),
    .estabelecidos_wr_addr_out(estabelecidos_wr_addr_out),
    .desativar_out(desativar_out), .desativar_addr_out(desativar_addr_out),
    .atualizar_valid_out(atualizar_valid_out), .atualizar_ready_in(atualizar_ready_in),
    .atualizar_endereco_out(atualizar_endereco_out),
    .atualizar_distancia_out(atualizar_distancia_out),
    .atualizar_anterior_out(atualizar_anterior_out), .pronto_out(pronto_out)
  );

  always #5 clk = ~clk;

  // Memory contents (written only by the stimulus) and read pipelines.
  logic [MV*SW-1:0] rel_mem [1024];
  logic             obs_mem [1024];
  logic             est_pre [1024];
  logic [1023:0]    est_wr;
  logic             clr_est = 1'b0;
  logic [MV*SW-1:0] rel_pipe [LAT];
  logic             obs_pipe [LAT];
  logic             est_pipe [LAT];

  // Read data appears LAT cycles after the strobe; junk otherwise.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      rel_pipe[i] <= rel_pipe[i-1];
      obs_pipe[i] <= obs_pipe[i-1];
      est_pipe[i] <= est_pipe[i-1];
    end
    rel_pipe[0] <= relacoes_rd_en_out ? rel_mem[relacoes_rd_addr_out] : '1;
    obs_pipe[0] <= obstaculos_rd_en_out ? obs_mem[obstaculos_rd_addr_out] : 1'b1;
    est_pipe[0] <= estabelecidos_rd_en_out ?
                   (est_pre[estabelecidos_rd_addr_out] | est_wr[estabelecidos_rd_addr_out]) : 1'b1;
    if (clr_est) est_wr <= '0;
    else if (estabelecidos_wr_en_out) est_wr[estabelecidos_wr_addr_out] <= 1'b1;
  end
  assign relacoes_rd_data_in      = rel_pipe[LAT-1];
  assign obstaculos_rd_data_in    = obs_pipe[LAT-1];
  assign estabelecidos_rd_data_in = est_pipe[LAT-1];

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [AW-1:0] q_des[$], q_rel[$];
  int            q_des_cyc[$];
  upd_t          q_upd[$];
  int n_pronto = 0, n_act = 0, busy_viol = 0, pair_err = 0;
  upd_t w_pl;
  assign w_pl = {atualizar_endereco_out, atualizar_distancia_out, atualizar_anterior_out};

  always @(negedge clk) begin
    if (desativar_out) begin
      q_des.push_back(desativar_addr_out);
      q_des_cyc.push_back(cyc);
      if (aa_ocupado_in) busy_viol++;
      if (!estabelecidos_wr_en_out || estabelecidos_wr_addr_out != desativar_addr_out) pair_err++;
    end else if (estabelecidos_wr_en_out) pair_err++;
    if (relacoes_rd_en_out) q_rel.push_back(relacoes_rd_addr_out);
    if (atualizar_valid_out && atualizar_ready_in) q_upd.push_back(w_pl);
    if (pronto_out) n_pronto++;
    if (relacoes_rd_en_out || obstaculos_rd_en_out || estabelecidos_rd_en_out ||
        desativar_out || atualizar_valid_out || pronto_out) n_act++;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  logic [AW-1:0] ch_addr [NA];
  logic [DW-1:0] ch_dist [NA];
  upd_t q_exp[$];

  task automatic mem_clear();
    for (int i = 0; i < 1024; i++) begin
      rel_mem[i] = '1; obs_mem[i] = 1'b0; est_pre[i] = 1'b0;
    end
  endtask

  task automatic set_slot(input int node, input int k, input int a, input int c);
    rel_mem[node][(MV-1-k)*SW +: SW] = {AW'(a), CW'(c)};
  endtask

  function automatic int exp_dist(input int d, input int c);
    int s = d + c;
`ifdef EVM_DIST_SATURACAO_EN
    return (s > (1 << DW) - 1) ? (1 << DW) - 1 : s;
`else
    return s % (1 << DW);
`endif
  endfunction

  // Reference: every approved node is established before any neighbour is
  // looked at, so a neighbour qualifies iff valid, not self, not an obstacle,
  // not pre-established and not one of the approved nodes.
  task automatic build_exp(input logic [NA-1:0] m);
    logic [SW-1:0] w;
    logic [AW-1:0] a;
    bit est;
    q_exp.delete();
    for (int ch = 0; ch < NA; ch++) if (m[ch]) begin
      for (int k = 0; k < MV; k++) begin
        w = rel_mem[ch_addr[ch]][(MV-1-k)*SW +: SW];
        a = w[SW-1:CW];
        if (a == INV || a == ch_addr[ch] || obs_mem[a]) continue;
        est = est_pre[a];
        for (int j = 0; j < NA; j++) if (m[j] && ch_addr[j] == a) est = 1'b1;
        if (est) continue;
        q_exp.push_back('{a: a, d: DW'(exp_dist(int'(ch_dist[ch]), int'(w[CW-1:0]))), p: ch_addr[ch]});
      end
    end
  endtask

  // One complete expansion: start pulse, bounded wait for pronto, then compare
  // desativar order, relation reads and update requests with the model.
  task automatic run(input string nm, input logic [NA-1:0] m, input int busy,
                     input int hold, input bit rnd);
    int d0, r0, u0, p0, held, stab_err, busy_left;
    bit done;
    upd_t hold_pl;
    logic [AW-1:0] exp_ch[$];
    build_exp(m);
    for (int i = 0; i < NA; i++) if (m[i]) exp_ch.push_back(ch_addr[i]);
    d0 = q_des.size(); r0 = q_rel.size(); u0 = q_upd.size(); p0 = n_pronto;
    clr_est = 1'b1;
    @(posedge clk); #1 clr_est = 1'b0;
    for (int i = 0; i < NA; i++) begin
      endereco_in[i*AW +: AW]  = ch_addr[i];
      distancia_in[i*DW +: DW] = ch_dist[i];
    end
    aprovado_in = m; expandir_in = 1'b1; atualizar_ready_in = 1'b0;
    @(posedge clk); #1 expandir_in = 1'b0;
    busy_left = busy; held = 0; stab_err = 0; done = 0; hold_pl = '0;
    for (int t = 0; t < 3000 && !done; t++) begin
      aa_ocupado_in = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (hold > 0) atualizar_ready_in = (held >= hold);
      else atualizar_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (hold > 0 && held < hold) begin
        if (atualizar_valid_out) begin
          if (held == 0) hold_pl = w_pl;
          else if (w_pl != hold_pl) stab_err++;
          held++;
        end else if (held > 0) stab_err++;
      end
      if (pronto_out) done = 1;
      @(posedge clk); #1;
    end
    aa_ocupado_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_pronto_pulses"}, 64'(n_pronto - p0), 64'd1);
    chk({nm, "_busy_desat"}, 64'(busy_viol), 64'd0);
    chk({nm, "_wr_desat_pair"}, 64'(pair_err), 64'd0);
    chk({nm, "_n_desat"}, 64'(q_des.size() - d0), 64'(exp_ch.size()));
    chk({nm, "_n_relrd"}, 64'(q_rel.size() - r0), 64'(exp_ch.size()));
    chk({nm, "_n_upd"}, 64'(q_upd.size() - u0), 64'(q_exp.size()));
    for (int i = 0; i < exp_ch.size() && d0 + i < q_des.size(); i++)
      chk({nm, "_desat_addr"}, 64'(q_des[d0+i]), 64'(exp_ch[i]));
    for (int i = 0; i < exp_ch.size() && r0 + i < q_rel.size(); i++)
      chk({nm, "_relrd_addr"}, 64'(q_rel[r0+i]), 64'(exp_ch[i]));
    if (busy == 0)
      for (int i = 0; i + 1 < exp_ch.size() && d0 + i + 1 < q_des.size(); i++)
        chk({nm, "_desat_consec"}, 64'(q_des_cyc[d0+i+1] - q_des_cyc[d0+i]), 64'd1);
    for (int i = 0; i < q_exp.size() && u0 + i < q_upd.size(); i++)
      chk({nm, "_upd"}, 64'(q_upd[u0+i]), 64'(q_exp[i]));
    if (hold > 0) begin
      chk({nm, "_hold_cycles"}, 64'(held), 64'(hold));
      chk({nm, "_hold_stable"}, 64'(stab_err), 64'd0);
      if (q_upd.size() > u0) chk({nm, "_hold_xfer"}, 64'(q_upd[u0]), 64'(hold_pl));
    end
  endtask

  initial begin
    int p0, a0;
    bit found;
    logic [NA-1:0] m;
    mem_clear();
    for (int i = 0; i < NA; i++) begin ch_addr[i] = '0; ch_dist[i] = '0; end
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(atualizar_valid_out), 64'd0);
    chk("rst_pronto", 64'(pronto_out), 64'd0);
    chk("rst_strobes", 64'({relacoes_rd_en_out, obstaculos_rd_en_out, estabelecidos_rd_en_out,
                              estabelecidos_wr_en_out, desativar_out}), 64'd0);
    chk("rst_addrs", 64'({relacoes_rd_addr_out, obstaculos_rd_addr_out, desativar_addr_out,
                            atualizar_endereco_out, atualizar_anterior_out}), 64'd0);
    chk("rst_dist", 64'(atualizar_distancia_out), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Mask 0101: node 5 (dist 3) then node 9 (dist 10); first request held 6 cycles.
    set_slot(5, 0, 7, 2); set_slot(5, 1, 1023, 0); set_slot(5, 2, 5, 1); set_slot(5, 3, 8, 3);
    obs_mem[8] = 1'b1;
    set_slot(9, 0, 5, 4); set_slot(9, 1, 12, 1);
    ch_addr[0] = 5; ch_dist[0] = 3; ch_addr[1] = 7; ch_dist[1] = 0;
    ch_addr[2] = 9; ch_dist[2] = 10; ch_addr[3] = 30; ch_dist[3] = 0;
    run("dirA", 4'b0101, 0, 6, 0);
    if (q_upd.size() >= 2) begin
      chk("dirA_first_req", 64'(q_upd[q_upd.size()-2]), 64'({10'd7, 6'd5, 10'd5}));
      chk("dirA_second_req", 64'(q_upd[q_upd.size()-1]), 64'({10'd12, 6'd11, 10'd9}));
    end else chk("dirA_req_count", 64'(q_upd.size()), 64'd2);

    // Same graph with the active evaluator busy for 4 cycles.
    run("busy", 4'b0101, 4, 0, 0);

    // Distance overflow: 62 + 4.
    mem_clear();
    set_slot(20, 0, 21, 4);
    ch_addr[0] = 20; ch_dist[0] = 62;
    p0 = q_upd.size();
    run("sat", 4'b0001, 0, 0, 0);
    if (q_upd.size() > p0) chk("sat_dist", 64'(q_upd[p0].d), 64'(SAT_EXP));
    else chk("sat_req_count", 64'(q_upd.size() - p0), 64'd1);

    // Zero mask straight to pronto; a start pulse during pronto is dropped.
    p0 = n_pronto;
    aprovado_in = '0; expandir_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 expandir_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("zero_mask_pronto", 64'(n_pronto - p0), 64'd1);

    // Reset while a request is pending.
    mem_clear();
    set_slot(40, 0, 41, 1);
    ch_addr[0] = 40; ch_dist[0] = 1;
    endereco_in[0 +: AW] = 40; distancia_in[0 +: DW] = 1;
    aprovado_in = 4'b0001; atualizar_ready_in = 1'b0; expandir_in = 1'b1;
    @(posedge clk); #1 expandir_in = 1'b0;
    found = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (atualizar_valid_out) found = 1;
    end
    chk("rst_mid_reach_emit", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(atualizar_valid_out), 64'd0);
    chk("rst_mid_payload", 64'({atualizar_endereco_out, atualizar_anterior_out}), 64'd0);
    p0 = n_pronto; a0 = n_act;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; atualizar_ready_in = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_mid_no_pronto", 64'(n_pronto - p0), 64'd0);
    chk("rst_mid_no_strobes", 64'(n_act - a0), 64'd0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      mem_clear();
      for (int n = 0; n < 32; n++) begin
        for (int k = 0; k < MV; k++)
          set_slot(n, k, ($urandom_range(0, 3) == 0) ? 1023 : int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 15)));
        obs_mem[n] = ($urandom_range(0, 3) == 0);
        est_pre[n] = ($urandom_range(0, 7) == 0);
      end
      for (int i = 0; i < NA; i++) begin
        ch_addr[i] = AW'($urandom_range(0, 31));
        ch_dist[i] = DW'($urandom_range(0, 63));
      end
      m = NA'($urandom_range(1, 15));
      run("rand", m, int'($urandom_range(0, 3)), 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
